// File: rtl/tdmi_frame_fetch_pkg.sv
// Shared TDMI register map, TDMI_ALL field positions and fetch FSM encoding.
package tdmi_frame_fetch_pkg;

  localparam logic [31:0] TDMI_ALL     = 32'h0000_0000;
  localparam logic [31:0] TDMI_DATA    = 32'h0000_0004;
  localparam logic [31:0] TDMI_CHANNEL = 32'h0000_0008;
  localparam logic [31:0] TDMI_START   = 32'h0000_000C;

  localparam int CH_MSB   = 12;
  localparam int CH_LSB   = 8;
  localparam int DATA_MSB = 7;
  localparam int NUM_CH   = 32;

  typedef enum logic [1:0] {
    ST_START_WR,
    ST_IDLE,
    ST_READ,
    ST_STORE
  } state_e;

endpackage

// File: rtl/tdm_frame_store.sv
// Double-buffered 2x32x8 frame store; writes land in the write bank, reads come from the other bank.
// Read port is registered (1 clk); swap flips banks on the same edge as a final write. No backpressure.
module tdm_frame_store
  import tdmi_frame_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_ch,
  input  logic [7:0] wr_data,
  input  logic       swap,
  input  logic [4:0] rd_ch,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [2*NUM_CH];
  logic       wr_bank_q;
  logic [7:0] rd_data_q;

  // Published bank is always the complement of the bank being filled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2*NUM_CH; i++) mem_q[i] <= '0;
      wr_bank_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) mem_q[{wr_bank_q, wr_ch}] <= wr_data;
      if (swap)  wr_bank_q <= ~wr_bank_q;
      rd_data_q <= mem_q[{~wr_bank_q, rd_ch}];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/tdmi_frame_fetch.sv
// Wishbone master that starts the TDMI slave, then reads TDMI_ALL on every new-data interrupt
// and assembles 32-channel frames. One read+store per event; a second queued event is held, a third is an overrun.
module tdmi_frame_fetch
  import tdmi_frame_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [31:0] START_ADR   = 32'h0000_000C,
  parameter logic [31:0] ALL_ADR     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_data_int,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [4:0]  rd_ch,
  output logic [7:0]  rd_data,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic [2:0]  err_flags
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q, evt;
  logic          pend_q, pend_d;
  logic [2:0]    err_q, err_d;
  logic [4:0]    exp_q, exp_d, ch_q, ch_d;
  logic [7:0]    byte_q, byte_d, cnt_q, cnt_d;
  logic          fv_q, fv_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cyc_q, cyc_d, we_q, we_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          tmo_expire, bus_done, bus_fail;
  logic          wr_en, swap;
  logic          unused_dat;

  assign unused_dat = ^i_wb_dat[31:CH_MSB+1];
  assign evt        = sync2_q & ~prev_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    err_d   = err_q;
    exp_d   = exp_q;
    ch_d    = ch_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    fv_d    = 1'b0;
    wr_en   = 1'b0;
    swap    = 1'b0;

    tmo_expire = cyc_q && (tmo_q == TMO_LAST);
    bus_done   = cyc_q && (i_wb_ack || i_wb_err || tmo_expire);
    bus_fail   = cyc_q && !i_wb_ack && (i_wb_err || tmo_expire);

    case (state_q)
      ST_START_WR: begin
        if (bus_done) begin
          state_d = ST_IDLE;
          if (bus_fail) err_d[1] = 1'b1;
        end
      end
      ST_IDLE: begin
        if (evt || pend_q) state_d = ST_READ;
      end
      ST_READ: begin
        if (bus_done) begin
          if (bus_fail) begin
            err_d[1] = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            ch_d    = i_wb_dat[CH_MSB:CH_LSB];
            byte_d  = i_wb_dat[DATA_MSB:0];
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        wr_en = 1'b1;
        if (ch_q != exp_q) err_d[2] = 1'b1;
        exp_d = ch_q + 5'd1;
        if (ch_q == 5'd31) begin
          swap  = 1'b1;
          fv_d  = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An event coinciding with a pending-driven IDLE exit stays queued.
    if (state_q == ST_IDLE) begin
      pend_d = pend_q && evt;
    end else if (evt) begin
      if (pend_q) err_d[0] = 1'b1;
      else        pend_d   = 1'b1;
    end

    tmo_d = (state_d != state_q || !cyc_q) ? '0 : tmo_q + TW'(1);

    // Bus outputs are registered from the next state so ack drops cyc on the same edge.
    cyc_d = 1'b0;
    we_d  = 1'b0;
    adr_d = '0;
    dat_d = '0;
    sel_d = '0;
    if (state_d == ST_START_WR) begin
      cyc_d = 1'b1;
      we_d  = 1'b1;
      adr_d = START_ADR;
      dat_d = 32'h1;
      sel_d = 4'hF;
    end else if (state_d == ST_READ) begin
      cyc_d = 1'b1;
      adr_d = ALL_ADR;
      sel_d = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_START_WR;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= '0;
      exp_q   <= '0;
      ch_q    <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      tmo_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= new_data_int;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      ch_q    <= ch_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  tdm_frame_store u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_ch   (ch_q),
    .wr_data (byte_q),
    .swap    (swap),
    .rd_ch   (rd_ch),
    .rd_data (rd_data)
  );

  assign o_wb_adr    = adr_q;
  assign o_wb_sel    = sel_q;
  assign o_wb_we     = we_q;
  assign o_wb_dat    = dat_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign frame_valid = fv_q;
  assign frame_cnt   = cnt_q;
  assign err_flags   = err_q;

endmodule

// File: doc/tdmi_frame_fetch.md
Name: tdmi_frame_fetch

Overview:
- Wishbone master placed directly downstream of the TDMI slave.
- On each TDMI new-data interrupt it reads the TDMI_ALL register and extracts {channel, data}.
- It stores each byte in a double-buffered 32-channel frame store. When channel 31 lands, it publishes the completed frame to the downstream processing logic (ADPCM channel engines).
- It issues the one-time TDMI_START write after reset.

Parameters:
- TIMEOUT_CYC, 64, max clk cycles an issued read or write may wait for ack/err before it is abandoned.
- START_ADR, 32'h0000_000C, TDMI_START register address.
- ALL_ADR, 32'h0000_0000, TDMI_ALL register address.

Ports:
- clk  in  1  wishbone clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- new_data_int  in  1  TDMI interrupt; ser_clk domain, asynchronous to clk.
- o_wb_adr  out  32  wishbone address.
- o_wb_sel  out  4  byte select; always 4'hF when a cycle is active.
- o_wb_we  out  1  write enable.
- o_wb_dat  out  32  write data.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  strobe.
- i_wb_dat  in  32  read data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_err  in  1  slave error.
- rd_ch  in  5  consumer channel select into the published frame.
- rd_data  out  8  published byte for rd_ch; registered, 1-cycle latency.
- frame_valid  out  1  one-cycle pulse when a new frame is published.
- frame_cnt  out  8  published-frame counter; wraps at 255->0.
- err_flags  out  3  sticky flags: [0] overrun, [1] bus error/timeout, [2] sequence error. Cleared only by reset.

Behaviour:
- Reset (async assert, sync release). All outputs 0. Both frame-store banks hold 0. Write bank = 0, published bank = 1. Expected channel = 0. FSM enters START_WR.
- Interrupt sync. new_data_int passes through a 2-flop synchronizer, then a rising-edge detect. The resulting `evt` pulse appears 3 clk after the async edge.
- FSM states and transitions:
  - START_WR: drive cyc=stb=we=1, adr=START_ADR, dat=32'h1. On ack, err, or timeout go to IDLE; err or timeout sets err_flags[1].
  - IDLE: on evt, or on pend=1, clear pend and go to READ.
  - READ: drive cyc=stb=1, we=0, adr=ALL_ADR, sel=4'hF. Signals stay stable until ack, err, or timeout.
    - ack: capture i_wb_dat[12:0] (ch = [12:8], byte = [7:0]), drop cyc/stb the same edge, go to STORE.
    - err or timeout: set err_flags[1], go to IDLE, capture nothing.
  - STORE: write byte to write_bank[ch].
    - If ch != expected, set err_flags[2] and resynchronise expected to ch.
    - expected <= ch+1 (mod 32).
    - If ch == 31: swap banks, pulse frame_valid, increment frame_cnt.
    - Go to IDLE.
- Timeout counter resets on entry to each bus state and counts clk while cyc=1. Reaching TIMEOUT_CYC aborts the cycle: cyc/stb drop next edge.
- Pending/overrun:
  - evt outside IDLE sets pend.
  - evt while pend=1 and not IDLE sets err_flags[0]; the extra event is dropped.
  - evt in the same cycle as the IDLE->READ transition is recorded as pend.
- Frame boundary:
  - A frame starting at channel 0 after an intermittent sync is handled by the expected-channel resync; no stall.
  - A bank swap publishes partially filled banks unchanged. Stale bytes are allowed.
- Consumer read: rd_data <= published_bank[rd_ch] each clk. After a swap, the next cycle reflects the new bank.
- Budget: one READ+STORE takes at most TIMEOUT_CYC+4 clk, well under the ~320 clk per channel at 2.048 MHz serial / 81.92 MHz clk.
- Reset mid-cycle: cyc/stb drop immediately (async). On release the FSM restarts at START_WR.

Decomposition:
- Shared package: TDMI register address constants (TDMI_ALL, TDMI_DATA, TDMI_CHANNEL, TDMI_START), TDMI_ALL field positions (CH_MSB=12, CH_LSB=8, DATA_MSB=7), and the FSM state encoding.
- One sub-module: tdm_frame_store. It holds the 2x32x8 double-buffered storage, the bank-select register, and the registered read port, with inputs wr_en/wr_ch/wr_data/swap.

Test Plan:
- Reset release, slave acks after 2 clk -> exactly one write: adr 0x0C, dat 0x1, we=1, sel=F; then cyc=0. err_flags=0.
- Emulated TDMI delivering ch 0..31 with data = 8'hA0+ch -> 32 reads at adr 0x0; frame_valid pulses once after ch 31; frame_cnt=1; rd_ch=5 gives rd_data=8'hA5 one clk later.
- Slave never acks a read -> cyc drops after 64 clk; err_flags[1]=1; next interrupt starts a new read normally.
- Three interrupt edges within one read (ack delayed 40 clk) -> second edge serviced after the current read; third edge sets err_flags[0]; 2 reads total.
- Channel sequence 0..9 then 0 (intermittent sync) -> err_flags[2]=1; no frame_valid; following 0..31 publishes a frame with frame_cnt=1.
- Assert reset while cyc=1 in READ -> cyc/stb/frame_valid 0 the same instant; after release, the START write is reissued.
